// File: rtl/punc_mem_arbiter.sv
// Two-master arbiter for the LC3 memory port: PUnC CPU vs. program loader.
// Round-robin on ties, loader burst lock bounded by a starvation counter.
module punc_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,

  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  input  logic              ldr_lock_i,
  output logic              ldr_gnt_o,
  output logic              ldr_rvalid_o,
  output logic [DATA_W-1:0] ldr_rdata_o,

  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    LDR_OWN  = 2'd2,
    LDR_LOCK = 2'd3
  } state_e;

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic cpu_win, ldr_win, force_yield;

  // State register: last_owner resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      lock_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Under lock the loader keeps the port until the counter forces one CPU slot.
  always_comb begin
    cpu_win     = 1'b0;
    ldr_win     = 1'b0;
    force_yield = 1'b0;
    if (state_q == LDR_LOCK && ldr_req_i) begin
      if (cpu_req_i && lock_cnt_q == MAX_LOCK_C) begin
        force_yield = 1'b1;
        cpu_win     = 1'b1;
      end else begin
        ldr_win = 1'b1;
      end
    end else if (cpu_req_i && ldr_req_i) begin
      if (last_owner_q) begin
        cpu_win = 1'b1;
      end else begin
        ldr_win = 1'b1;
      end
    end else begin
      cpu_win = cpu_req_i;
      ldr_win = ldr_req_i;
    end
  end

  // Next-state logic; a forced yield leaves the lock in place if the loader still wants it.
  always_comb begin
    state_d      = IDLE;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    if (ldr_gnt_o) begin
      state_d      = ldr_lock_i ? LDR_LOCK : LDR_OWN;
      last_owner_d = 1'b1;
    end else if (cpu_gnt_o) begin
      state_d      = (force_yield && ldr_lock_i) ? LDR_LOCK : CPU_OWN;
      last_owner_d = 1'b0;
    end
    if (!cpu_req_i || cpu_gnt_o || state_d != LDR_LOCK) begin
      lock_cnt_d = 8'd0;
    end else if (ldr_gnt_o && ldr_lock_i && lock_cnt_q < MAX_LOCK_C) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  // Output logic: grants are gated by reset so they drop as soon as reset asserts.
  always_comb begin
    cpu_gnt_o    = cpu_win & rst_ni;
    ldr_gnt_o    = ldr_win & rst_ni;
    cpu_stall_o  = cpu_req_i & ~cpu_gnt_o;
    mem_en_o     = cpu_gnt_o | ldr_gnt_o;
    mem_we_o     = 1'b0;
    mem_addr_o   = mem_addr_q;
    mem_wdata_o  = mem_wdata_q;
    if (cpu_gnt_o) begin
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (ldr_gnt_o) begin
      mem_we_o    = ldr_we_i;
      mem_addr_o  = ldr_addr_i;
      mem_wdata_o = ldr_wdata_i;
    end
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
  end

  // Read return: memory data shows up the cycle after the strobe and is captured for hold.
  always_comb begin
    rd_pend_d    = mem_en_o & ~mem_we_o;
    rd_owner_d   = ldr_gnt_o;
    cpu_rvalid_o = rd_pend_q & ~rd_owner_q;
    ldr_rvalid_o = rd_pend_q & rd_owner_q;
    cpu_rdata_d  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
    ldr_rdata_d  = ldr_rvalid_o ? mem_rdata_i : ldr_rdata_q;
    cpu_rdata_o  = cpu_rdata_d;
    ldr_rdata_o  = ldr_rdata_d;
  end

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed-vector bench for punc_mem_arbiter with a small synchronous-read memory model.
module tb_punc_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid;
  logic [15:0] cpu_rdata, ldr_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        pl_en;
  logic [15:0] pl_addr, pl_data;
  logic [15:0] mem [0:65535];

  int checks;
  int failures;

  typedef struct {
    logic        cpuReq, cpuWe;
    logic [15:0] cpuAddr, cpuWdata;
    logic        ldrReq, ldrWe;
    logic [15:0] ldrAddr, ldrWdata;
    logic        ldrLock;
    logic        expCpuGnt, expLdrGnt, expCpuRv, expLdrRv, expMemEn, expMemWe;
    logic [15:0] expMemAddr, expMemWdata, expCpuRdata, expLdrRdata;
  } vec_t;

  vec_t vecs [14];

  punc_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_lock_i(ldr_lock), .ldr_gnt_o(ldr_gnt), .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory with a side port for preloading contents.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    cpu_req   = v.cpuReq;
    cpu_we    = v.cpuWe;
    cpu_addr  = v.cpuAddr;
    cpu_wdata = v.cpuWdata;
    ldr_req   = v.ldrReq;
    ldr_we    = v.ldrWe;
    ldr_addr  = v.ldrAddr;
    ldr_wdata = v.ldrWdata;
    ldr_lock  = v.ldrLock;
  endtask

  task automatic clearInputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    nextCycle();
    pl_en = 0;
  endtask

  task automatic applyReset();
    clearInputs();
    rst_n = 0;
    nextCycle();
    nextCycle();
    rst_n = 1;
  endtask

  initial begin
    logic [3:0] lockExp [22];
    logic       lastOwner, prevRd, prevOwner;
    logic       rc, rl, ec, el;

    checks = 0;
    failures = 0;
    pl_en = 0; pl_addr = 0; pl_data = 0;
    clearInputs();
    rst_n = 0;

    vecs[0]  = '{1,0,16'h3000,16'h0000, 0,0,16'h0000,16'h0000, 0, 1,0,0,0,1,0, 16'h3000,16'h0000,16'h0000,16'h0000};
    vecs[1]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0, 0,0,1,0,0,0, 16'h3000,16'h0000,16'h1234,16'h0000};
    vecs[2]  = '{1,0,16'h3001,16'h0000, 1,0,16'h5000,16'h0000, 0, 0,1,0,0,1,0, 16'h5000,16'h0000,16'h1234,16'h0000};
    vecs[3]  = '{1,0,16'h3001,16'h0000, 1,0,16'h5000,16'h0000, 0, 1,0,0,1,1,0, 16'h3001,16'h0000,16'h1234,16'hAAAA};
    vecs[4]  = '{1,0,16'h3000,16'h0000, 1,0,16'h5001,16'h0000, 0, 0,1,1,0,1,0, 16'h5001,16'h0000,16'h7777,16'hAAAA};
    vecs[5]  = '{1,0,16'h3000,16'h0000, 1,1,16'h0040,16'hBEEF, 0, 1,0,0,1,1,0, 16'h3000,16'h0000,16'h7777,16'h5555};
    vecs[6]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0040,16'hBEEF, 0, 0,1,1,0,1,1, 16'h0040,16'hBEEF,16'h1234,16'h5555};
    vecs[7]  = '{1,0,16'h0040,16'h0000, 0,0,16'h0000,16'h0000, 0, 1,0,0,0,1,0, 16'h0040,16'h0000,16'h1234,16'h5555};
    vecs[8]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0, 0,0,1,0,0,0, 16'h0040,16'h0000,16'hBEEF,16'h5555};
    vecs[9]  = '{1,1,16'h0041,16'h1111, 1,0,16'h0040,16'h0000, 0, 0,1,0,0,1,0, 16'h0040,16'h0000,16'hBEEF,16'h5555};
    vecs[10] = '{1,1,16'h0041,16'h1111, 0,0,16'h0000,16'h0000, 0, 1,0,0,1,1,1, 16'h0041,16'h1111,16'hBEEF,16'hBEEF};
    vecs[11] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0, 0,0,0,0,0,0, 16'h0041,16'h1111,16'hBEEF,16'hBEEF};
    vecs[12] = '{1,0,16'h0041,16'h0000, 0,0,16'h0000,16'h0000, 0, 1,0,0,0,1,0, 16'h0041,16'h0000,16'hBEEF,16'hBEEF};
    vecs[13] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0, 0,0,1,0,0,0, 16'h0041,16'h0000,16'h1111,16'hBEEF};

    preload(16'h3000, 16'h1234);
    preload(16'h3001, 16'h7777);
    preload(16'h5000, 16'hAAAA);
    preload(16'h5001, 16'h5555);

    // Reset state, with a request held to show grants are suppressed.
    cpu_req = 1; ldr_req = 1;
    @(negedge clk);
    checkOutput("rst_cpu_gnt", {15'd0, cpu_gnt}, 16'd0);
    checkOutput("rst_ldr_gnt", {15'd0, ldr_gnt}, 16'd0);
    checkOutput("rst_mem_en", {15'd0, mem_en}, 16'd0);
    checkOutput("rst_mem_we", {15'd0, mem_we}, 16'd0);
    checkOutput("rst_rvalid", {14'd0, cpu_rvalid, ldr_rvalid}, 16'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 16'd0);
    checkOutput("rst_ldr_rdata", ldr_rdata, 16'd0);
    applyReset();

    // Table-driven main sequence.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_cpu_gnt", i), {15'd0, cpu_gnt}, {15'd0, vecs[i].expCpuGnt});
      checkOutput($sformatf("v%0d_ldr_gnt", i), {15'd0, ldr_gnt}, {15'd0, vecs[i].expLdrGnt});
      checkOutput($sformatf("v%0d_cpu_rvalid", i), {15'd0, cpu_rvalid}, {15'd0, vecs[i].expCpuRv});
      checkOutput($sformatf("v%0d_ldr_rvalid", i), {15'd0, ldr_rvalid}, {15'd0, vecs[i].expLdrRv});
      checkOutput($sformatf("v%0d_mem_en", i), {15'd0, mem_en}, {15'd0, vecs[i].expMemEn});
      checkOutput($sformatf("v%0d_mem_we", i), {15'd0, mem_we}, {15'd0, vecs[i].expMemWe});
      checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].expMemAddr);
      checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].expMemWdata);
      checkOutput($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].expCpuRdata);
      checkOutput($sformatf("v%0d_ldr_rdata", i), ldr_rdata, vecs[i].expLdrRdata);
      checkOutput($sformatf("v%0d_cpu_stall", i), {15'd0, cpu_stall},
                  {15'd0, vecs[i].cpuReq & ~vecs[i].expCpuGnt});
      nextCycle();
    end

    // Lock burst: 1 = CPU grant, 2 = loader grant; lock drops at cycle 19.
    applyReset();
    for (int i = 0; i < 22; i++) lockExp[i] = 4'd2;
    lockExp[0] = 4'd1; lockExp[9] = 4'd1; lockExp[18] = 4'd1; lockExp[20] = 4'd1;
    for (int i = 0; i < 22; i++) begin
      cpu_req = 1; cpu_addr = 16'h3000;
      ldr_req = 1; ldr_addr = 16'h5000;
      ldr_lock = (i < 19);
      @(negedge clk);
      checkOutput($sformatf("lock_c%0d_gnt", i), {14'd0, ldr_gnt, cpu_gnt}, {12'd0, lockExp[i]});
      nextCycle();
    end

    // Reset asserted while a CPU read is outstanding.
    clearInputs();
    applyReset();
    cpu_req = 1; cpu_addr = 16'h3000;
    @(negedge clk);
    checkOutput("rstmid_gnt_before", {15'd0, cpu_gnt}, 16'd1);
    #1 rst_n = 0;
    #1;
    checkOutput("rstmid_gnt_clear", {15'd0, cpu_gnt}, 16'd0);
    checkOutput("rstmid_mem_en_clear", {15'd0, mem_en}, 16'd0);
    @(negedge clk);
    checkOutput("rstmid_no_rvalid", {15'd0, cpu_rvalid}, 16'd0);
    checkOutput("rstmid_rdata", cpu_rdata, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    ldr_req = 1; ldr_addr = 16'h5000;
    @(negedge clk);
    checkOutput("rstmid_first_tie", {14'd0, ldr_gnt, cpu_gnt}, 16'd1);
    checkOutput("rstmid_still_no_rvalid", {15'd0, cpu_rvalid}, 16'd0);
    nextCycle();

    // Random unlocked traffic against a round-robin model.
    applyReset();
    lastOwner = 1; prevRd = 0; prevOwner = 0;
    for (int i = 0; i < 1000; i++) begin
      rc = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      cpu_req = rc; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 16'($urandom_range(0, 255)); cpu_wdata = 16'($urandom);
      ldr_req = rl; ldr_we = 1'($urandom_range(0, 1));
      ldr_addr = 16'($urandom_range(0, 255)); ldr_wdata = 16'($urandom);
      ldr_lock = 0;
      if (rc && rl) begin
        ec = lastOwner; el = ~lastOwner;
      end else begin
        ec = rc; el = rl;
      end
      @(negedge clk);
      if (cpu_gnt && ldr_gnt) begin
        checks++;
        failures++;
        $display("[TB] FAIL rand_onehot: both grants high at cycle %0d", i);
      end else begin
        checks++;
      end
      checkOutput("rand_gnt", {14'd0, ldr_gnt, cpu_gnt}, {14'd0, el, ec});
      checkOutput("rand_rvalid", {14'd0, ldr_rvalid, cpu_rvalid},
                  {14'd0, prevRd & prevOwner, prevRd & ~prevOwner});
      if (ec || el) lastOwner = el;
      prevRd    = (ec & ~cpu_we) | (el & ~ldr_we);
      prevOwner = el;
      nextCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
